// File: rtl/video_timing.sv
// Raster timing generator: 400-pixel lines, NTSC/PAL frames, optional 2x line doubling.
// Mode inputs are captured at frame start so a frame never changes geometry halfway through.
module video_timing #(
  parameter int unsigned H_TOTAL       = 400,
  parameter int unsigned H_BLANK_START = 320,
  parameter int unsigned H_SYNC_START  = 336,
  parameter int unsigned H_SYNC_END    = 367
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pal,
  input  logic       scandouble,
  output logic       ce_pix,
  output logic [9:0] hcount,
  output logic [8:0] vcount,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_BLK  = 10'(H_BLANK_START);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE   = 10'(H_SYNC_END);

  logic [1:0] div_q, div_d;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] line_q, line_d;
  logic [8:0] vcount_q, vcount_d;
  logic       ce_q, ce_d;
  logic       hblank_q, hblank_d;
  logic       hsync_q, hsync_d;
  logic       vblank_q, vblank_d;
  logic       vsync_q, vsync_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic       pal_q, pal_d;
  logic       sd_q, sd_d;

  logic       tick;
  logic       hwrap;
  logic       fwrap;
  logic [9:0] line_last;
  logic [8:0] v_last;

  always_comb begin
    div_d     = div_q + 2'd1;
    tick      = sd_q ? div_q[0] : (div_q == 2'd3);
    hwrap     = (hcount_q == H_LAST);
    line_last = sd_q ? (pal_q ? 10'd623 : 10'd523) : (pal_q ? 10'd311 : 10'd261);
    v_last    = pal_q ? 9'd311 : 9'd261;
    fwrap     = hwrap && (line_q == line_last);

    hcount_d = hcount_q;
    line_d   = line_q;
    if (tick) begin
      hcount_d = hwrap ? 10'd0 : hcount_q + 10'd1;
      if (hwrap) begin
        line_d = fwrap ? 10'd0 : line_q + 10'd1;
      end
    end

    // In doubled mode two output lines share one source line.
    vcount_d = sd_q ? line_d[9:1] : line_d[8:0];

    hblank_d = (hcount_d >= H_BLK);
    hsync_d  = (hcount_d >= H_SS) && (hcount_d <= H_SE);
    vblank_d = (vcount_d >= 9'd240) && (vcount_d <= v_last);
    vsync_d  = pal_q ? ((vcount_d >= 9'd270) && (vcount_d <= 9'd272))
                     : ((vcount_d >= 9'd244) && (vcount_d <= 9'd246));

    ce_d = tick;
    ls_d = tick && hwrap;
    fs_d = tick && fwrap;

    pal_d = (!reset_n || fs_q) ? pal        : pal_q;
    sd_d  = (!reset_n || fs_q) ? scandouble : sd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= 2'd0;
      hcount_q <= 10'd0;
      line_q   <= 10'd0;
      vcount_q <= 9'd0;
      ce_q     <= 1'b0;
      hblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vblank_q <= 1'b0;
      vsync_q  <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      line_q   <= line_d;
      vcount_q <= vcount_d;
      ce_q     <= ce_d;
      hblank_q <= hblank_d;
      hsync_q  <= hsync_d;
      vblank_q <= vblank_d;
      vsync_q  <= vsync_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  // Mode follows the inputs while held in reset, so it needs no async value.
  always_ff @(posedge clk) begin
    pal_q <= pal_d;
    sd_q  <= sd_d;
  end

  assign ce_pix      = ce_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign HBlank      = hblank_q;
  assign HSync       = hsync_q;
  assign VBlank      = vblank_q;
  assign VSync       = vsync_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench: full-size instance for horizontal/reset behaviour, short-line instance
// (6 pixels per line) so whole frames fit in a short run for vertical behaviour.
module tb_video_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_pal, a_sd, a_ce, a_hb, a_hs, a_vb, a_vs, a_ls, a_fs;
  logic [9:0] a_hcount;
  logic [8:0] a_vcount;
  logic       b_rst_n, b_pal, b_sd, b_ce, b_hb, b_hs, b_vb, b_vs, b_ls, b_fs;
  logic [9:0] b_hcount;
  logic [8:0] b_vcount;

  video_timing u_full (
    .clk(clk), .reset_n(a_rst_n), .pal(a_pal), .scandouble(a_sd),
    .ce_pix(a_ce), .hcount(a_hcount), .vcount(a_vcount),
    .HBlank(a_hb), .HSync(a_hs), .VBlank(a_vb), .VSync(a_vs),
    .line_start(a_ls), .frame_start(a_fs)
  );

  video_timing #(.H_TOTAL(6), .H_BLANK_START(4), .H_SYNC_START(5), .H_SYNC_END(5)) u_short (
    .clk(clk), .reset_n(b_rst_n), .pal(b_pal), .scandouble(b_sd),
    .ce_pix(b_ce), .hcount(b_hcount), .vcount(b_vcount),
    .HBlank(b_hb), .HSync(b_hs), .VBlank(b_vb), .VSync(b_vs),
    .line_start(b_ls), .frame_start(b_fs)
  );

  int checks = 0;
  int failures = 0;
  int rule_viol = 0;
  int vedge_viol = 0;
  int cyc;
  int m_cyc, m_ce, m_hs, m_hb, m_hs_first;
  int m_lines, m_vs_lines, m_vs_first, m_vs_last, m_vb_first, m_vmax;

  // Every cycle: HBlank tracks hcount, pulses only ride on ce_pix.
  always @(negedge clk) begin
    if (a_hb !== (a_hcount >= 10'd320)) rule_viol++;
    if (b_hb !== (b_hcount >= 10'd4)) rule_viol++;
    if ((a_ls || a_fs) && !a_ce) rule_viol++;
    if ((b_ls || b_fs) && !b_ce) rule_viol++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return a_ls;
      1: return a_ce && (a_hcount == 10'd200);
      2: return b_fs;
      3: return b_ls;
      4: return b_vcount == 9'd100;
      5: return b_ce && (b_hcount == 10'd2) && (b_vcount == 9'd150);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int budget, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (!cond(sel) && cycles < budget);
    chk({tag, "_reached"}, int'(cond(sel)), 1);
  endtask

  task automatic measure_a_line(input string tag);
    m_cyc = 0; m_ce = 0; m_hs = 0; m_hb = 0; m_hs_first = -1;
    do begin
      step(1);
      m_cyc++;
      if (a_ce) m_ce++;
      if (a_ce && a_hs) m_hs++;
      if (a_ce && a_hb) m_hb++;
      if (a_hs && m_hs_first < 0) m_hs_first = int'(a_hcount);
    end while (!a_ls && m_cyc < 4000);
    chk({tag, "_reached"}, int'(a_ls), 1);
  endtask

  task automatic measure_b_frame(input string tag);
    logic pvb, pvs;
    pvb = b_vb; pvs = b_vs;
    m_cyc = 0; m_lines = 0; m_vs_lines = 0; m_vmax = 0;
    m_vs_first = 999; m_vs_last = -1; m_vb_first = 999;
    do begin
      step(1);
      m_cyc++;
      if (b_ls) m_lines++;
      if (b_ls && b_vs) m_vs_lines++;
      if (((b_vb !== pvb) || (b_vs !== pvs)) && !(b_ls && b_hcount == 10'd0)) vedge_viol++;
      if (b_vb !== (b_vcount >= 9'd240)) vedge_viol++;
      pvb = b_vb; pvs = b_vs;
      if (int'(b_vcount) > m_vmax) m_vmax = int'(b_vcount);
      if (b_vs && int'(b_vcount) < m_vs_first) m_vs_first = int'(b_vcount);
      if (b_vs && int'(b_vcount) > m_vs_last) m_vs_last = int'(b_vcount);
      if (b_vb && int'(b_vcount) < m_vb_first) m_vb_first = int'(b_vcount);
    end while (!b_fs && m_cyc < 10000);
    chk({tag, "_reached"}, int'(b_fs), 1);
  endtask

  initial begin
    a_rst_n = 1'b0; a_pal = 1'b0; a_sd = 1'b0;
    b_rst_n = 1'b0; b_pal = 1'b0; b_sd = 1'b0;
    step(3);
    chk("a_reset_hcount", int'(a_hcount), 0);
    chk("a_reset_vcount", int'(a_vcount), 0);
    chk("a_reset_outs", int'({a_ce, a_hb, a_hs, a_vb, a_vs, a_ls, a_fs}), 0);

    // 15 kHz: first ce_pix on the 4th edge, then every 4 clk.
    a_rst_n = 1'b1;
    step(3);
    chk("a_no_early_ce", int'(a_ce), 0);
    step(1);
    chk("a_first_ce", int'(a_ce), 1);
    chk("a_first_hcount", int'(a_hcount), 1);
    step(1);
    chk("a_ce_width", int'(a_ce), 0);
    step(3);
    chk("a_second_ce", int'(a_ce), 1);
    chk("a_second_hcount", int'(a_hcount), 2);

    wait_for("a_first_line", 0, 2000, cyc);
    chk("a_first_line_cycles", cyc, 1592);
    chk("a_line1_vcount", int'(a_vcount), 1);
    chk("a_line1_hcount", int'(a_hcount), 0);
    chk("a_no_frame_start", int'(a_fs), 0);

    measure_a_line("a_line15");
    chk("a_line15_period", m_cyc, 1600);
    chk("a_line15_ce", m_ce, 400);
    chk("a_line15_hsync", m_hs, 32);
    chk("a_line15_hblank", m_hb, 80);
    chk("a_line15_hsync_first", m_hs_first, 336);

    // Asynchronous reset mid-line, restart in 31 kHz mode.
    wait_for("a_hc200", 1, 2000, cyc);
    a_rst_n = 1'b0;
    #1;
    chk("a_async_hcount", int'(a_hcount), 0);
    chk("a_async_vcount", int'(a_vcount), 0);
    chk("a_async_outs", int'({a_ce, a_hb, a_hs, a_vb, a_vs, a_ls, a_fs}), 0);
    a_sd = 1'b1;
    step(2);
    a_rst_n = 1'b1;
    step(1);
    chk("a_sd_no_early_ce", int'(a_ce), 0);
    step(1);
    chk("a_sd_first_ce", int'(a_ce), 1);
    chk("a_sd_first_hcount", int'(a_hcount), 1);
    wait_for("a_sd_line", 0, 1000, cyc);
    measure_a_line("a_line31");
    chk("a_line31_period", m_cyc, 800);
    chk("a_line31_ce", m_ce, 400);
    chk("a_line31_hsync", m_hs, 32);

    // Vertical behaviour on the short-line instance (6 pixels per line).
    b_rst_n = 1'b1;
    wait_for("b_first_frame", 2, 10000, cyc);
    chk("b_first_frame_cycles", cyc, 6288);
    chk("b_fs_vcount", int'(b_vcount), 0);
    chk("b_fs_hcount", int'(b_hcount), 0);

    measure_b_frame("b_ntsc");
    chk("b_ntsc_period", m_cyc, 6288);
    chk("b_ntsc_lines", m_lines, 262);
    chk("b_ntsc_vmax", m_vmax, 261);
    chk("b_ntsc_vs_lines", m_vs_lines, 3);
    chk("b_ntsc_vs_first", m_vs_first, 244);
    chk("b_ntsc_vs_last", m_vs_last, 246);
    chk("b_ntsc_vb_first", m_vb_first, 240);

    wait_for("b_v100", 4, 10000, cyc);
    b_pal = 1'b1;
    measure_b_frame("b_toggle");
    chk("b_toggle_vmax", m_vmax, 261);
    chk("b_toggle_lines", m_lines, 162);

    measure_b_frame("b_pal");
    chk("b_pal_period", m_cyc, 7488);
    chk("b_pal_lines", m_lines, 312);
    chk("b_pal_vmax", m_vmax, 311);
    chk("b_pal_vs_lines", m_vs_lines, 3);
    chk("b_pal_vs_first", m_vs_first, 270);
    chk("b_pal_vs_last", m_vs_last, 272);
    chk("b_pal_vb_first", m_vb_first, 240);

    b_pal = 1'b0;
    b_sd = 1'b1;
    measure_b_frame("b_switch");
    chk("b_switch_lines", m_lines, 524);

    measure_b_frame("b_dbl");
    chk("b_dbl_period", m_cyc, 6288);
    chk("b_dbl_lines", m_lines, 524);
    chk("b_dbl_vmax", m_vmax, 261);
    chk("b_dbl_vs_lines", m_vs_lines, 6);
    chk("b_dbl_vs_first", m_vs_first, 244);
    chk("b_dbl_vs_last", m_vs_last, 246);
    chk("b_dbl_vb_first", m_vb_first, 240);

    wait_for("b_dbl_l1", 3, 100, cyc);
    chk("b_dbl_l1_vcount", int'(b_vcount), 0);
    wait_for("b_dbl_l2", 3, 100, cyc);
    chk("b_dbl_l2_vcount", int'(b_vcount), 1);

    wait_for("b_v150", 5, 8000, cyc);
    b_rst_n = 1'b0;
    #1;
    chk("b_async_hcount", int'(b_hcount), 0);
    chk("b_async_vcount", int'(b_vcount), 0);
    chk("b_async_outs", int'({b_ce, b_hb, b_hs, b_vb, b_vs, b_ls, b_fs}), 0);
    step(2);
    b_rst_n = 1'b1;
    step(1);
    chk("b_rel_no_early_ce", int'(b_ce), 0);
    step(1);
    chk("b_rel_first_ce", int'(b_ce), 1);
    chk("b_rel_first_hcount", int'(b_hcount), 1);

    chk("per_cycle_rules", rule_viol, 0);
    chk("vertical_edges", vedge_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
